// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control path: opcodes, ALU codes and the control bundle.
package ctrl_pkg;

  localparam int unsigned OPCODE_W = 6;
  localparam int unsigned ALUOP_W  = 3;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_ADDI  = 3'b011;

  typedef struct packed {
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               branch;
    logic               mem_read;
    logic               mem_write;
    logic               mem_to_reg;
    logic               reg_write;
  } ctrl_bundle_t;

  localparam int unsigned CTRL_BUNDLE_W = $bits(ctrl_bundle_t);
  localparam ctrl_bundle_t CTRL_BUBBLE = '0;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic reg_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } mem_wb_ctrl_t;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/control_decoder.sv
// Combinational opcode -> control bundle table. CTRL_ILLEGAL_TRAP_EN adds an illegal-opcode output.
module control_decoder
  import ctrl_pkg::*;
(
  input  logic [OPCODE_W-1:0] op_code_i,
  input  logic                id_valid_i,
  output ctrl_bundle_t        bundle_o
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                illegal_o
`endif
);

  always_comb begin
    bundle_o = CTRL_BUBBLE;
    if (id_valid_i) begin
      unique case (op_code_i)
        OP_RTYPE: begin
          bundle_o.reg_dst   = 1'b1;
          bundle_o.reg_write = 1'b1;
          bundle_o.alu_op    = ALU_RTYPE;
        end
        OP_LW: begin
          bundle_o.alu_src    = 1'b1;
          bundle_o.mem_to_reg = 1'b1;
          bundle_o.reg_write  = 1'b1;
          bundle_o.mem_read   = 1'b1;
          bundle_o.alu_op     = ALU_ADD;
        end
        OP_SW: begin
          bundle_o.alu_src   = 1'b1;
          bundle_o.mem_write = 1'b1;
          bundle_o.alu_op    = ALU_ADD;
        end
        OP_BEQ: begin
          bundle_o.branch = 1'b1;
          bundle_o.alu_op = ALU_SUB;
        end
        OP_ADDI: begin
          bundle_o.alu_src   = 1'b1;
          bundle_o.reg_write = 1'b1;
          bundle_o.alu_op    = ALU_ADDI;
        end
        default: bundle_o = CTRL_BUBBLE;
      endcase
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  assign illegal_o = id_valid_i && !is_legal_op(op_code_i);
`endif

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined control: decode in ID, carry bundle through ID/EX, EX/MEM, MEM/WB with stall/freeze/flush.
// Optional sticky illegal-opcode flag under CTRL_ILLEGAL_TRAP_EN.
module pipelined_control_unit
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH   = 6,
  parameter int unsigned ALUOP_WIDTH    = 3,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      resetN,
  input  logic [OPCODE_WIDTH-1:0]   opCode,
  input  logic                      idValid,
  input  logic [REG_ADDR_WIDTH-1:0] idRs,
  input  logic [REG_ADDR_WIDTH-1:0] idRt,
  input  logic [REG_ADDR_WIDTH-1:0] exRt,
  input  logic                      memBusy,
  input  logic                      branchTaken,
  output logic                      pcWrite,
  output logic                      ifIdWrite,
  output logic                      ifIdFlush,
  output logic                      exRegDst,
  output logic                      exAluSrc,
  output logic [ALUOP_WIDTH-1:0]    exAluOp,
  output logic                      exBranch,
  output logic                      memMemRead,
  output logic                      memMemWrite,
  output logic                      wbMemToReg,
  output logic                      wbRegWrite
`ifdef CTRL_ILLEGAL_TRAP_EN
  ,
  output logic                      illegalOp
`endif
);

  ctrl_bundle_t id_bundle;
  ctrl_bundle_t id_ex_d, id_ex_q;
  ex_mem_ctrl_t ex_mem_d, ex_mem_q;
  mem_wb_ctrl_t mem_wb_d, mem_wb_q;
  logic         id_reads_rt;
  logic         load_use;

  control_decoder u_control_decoder (
    .op_code_i  (opCode),
    .id_valid_i (idValid),
    .bundle_o   (id_bundle)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_o  (id_illegal)
`endif
  );

  // Only these formats actually read rt in ID; lw/addi write it instead.
  assign id_reads_rt = (opCode == OP_RTYPE) || (opCode == OP_BEQ) || (opCode == OP_SW);

  assign load_use = id_ex_q.mem_read && (exRt != '0) && idValid &&
                    ((exRt == idRs) || ((exRt == idRt) && id_reads_rt));

  always_comb begin
    id_ex_d   = id_ex_q;
    ex_mem_d  = ex_mem_q;
    mem_wb_d  = mem_wb_q;
    pcWrite   = 1'b1;
    ifIdWrite = 1'b1;
    ifIdFlush = 1'b0;

    if (memBusy) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
    end else begin
      ex_mem_d = '{mem_read:   id_ex_q.mem_read,
                   mem_write:  id_ex_q.mem_write,
                   mem_to_reg: id_ex_q.mem_to_reg,
                   reg_write:  id_ex_q.reg_write};
      mem_wb_d = '{mem_to_reg: ex_mem_q.mem_to_reg,
                   reg_write:  ex_mem_q.reg_write};
      if (branchTaken) begin
        id_ex_d   = CTRL_BUBBLE;
        ifIdFlush = 1'b1;
      end else if (load_use) begin
        id_ex_d   = CTRL_BUBBLE;
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
      end else begin
        id_ex_d = id_bundle;
      end
    end

    // Front end stays enabled while reset is held, whatever the other inputs say.
    if (!resetN) begin
      pcWrite   = 1'b1;
      ifIdWrite = 1'b1;
      ifIdFlush = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      id_ex_q  <= CTRL_BUBBLE;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic illegal_d, illegal_q;

  assign illegal_d = illegal_q || (id_illegal && !memBusy && !branchTaken);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= illegal_d;
    end
  end

  assign illegalOp = illegal_q;
`endif

  assign exRegDst    = id_ex_q.reg_dst;
  assign exAluSrc    = id_ex_q.alu_src;
  assign exAluOp     = id_ex_q.alu_op;
  assign exBranch    = id_ex_q.branch;
  assign memMemRead  = ex_mem_q.mem_read;
  assign memMemWrite = ex_mem_q.mem_write;
  assign wbMemToReg  = mem_wb_q.mem_to_reg;
  assign wbRegWrite  = mem_wb_q.reg_write;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Randomised bench for pipelined_control_unit against an instruction-level pipeline model.
// Checks illegalOp too when built with CTRL_ILLEGAL_TRAP_EN.
module tb_pipelined_control_unit;

  localparam int K_NOP  = 0;
  localparam int K_R    = 1;
  localparam int K_LW   = 2;
  localparam int K_SW   = 3;
  localparam int K_BEQ  = 4;
  localparam int K_ADDI = 5;

  localparam logic [5:0] C_R    = 6'b000000;
  localparam logic [5:0] C_LW   = 6'b100011;
  localparam logic [5:0] C_SW   = 6'b101011;
  localparam logic [5:0] C_BEQ  = 6'b000100;
  localparam logic [5:0] C_ADDI = 6'b001000;
  localparam logic [5:0] C_BAD  = 6'b111111;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [5:0] opCode = '0;
  logic       idValid = 1'b0;
  logic [4:0] idRs = '0, idRt = '0, exRt = '0;
  logic       memBusy = 1'b1;
  logic       branchTaken = 1'b0;
  logic       pcWrite, ifIdWrite, ifIdFlush;
  logic       exRegDst, exAluSrc, exBranch;
  logic [2:0] exAluOp;
  logic       memMemRead, memMemWrite, wbMemToReg, wbRegWrite;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegalOp;
`endif

  pipelined_control_unit dut (
    .clk         (clk),
    .resetN      (resetN),
    .opCode      (opCode),
    .idValid     (idValid),
    .idRs        (idRs),
    .idRt        (idRt),
    .exRt        (exRt),
    .memBusy     (memBusy),
    .branchTaken (branchTaken),
    .pcWrite     (pcWrite),
    .ifIdWrite   (ifIdWrite),
    .ifIdFlush   (ifIdFlush),
    .exRegDst    (exRegDst),
    .exAluSrc    (exAluSrc),
    .exAluOp     (exAluOp),
    .exBranch    (exBranch),
    .memMemRead  (memMemRead),
    .memMemWrite (memMemWrite),
    .wbMemToReg  (wbMemToReg),
    .wbRegWrite  (wbRegWrite)
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    .illegalOp   (illegalOp)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: which instruction kind sits in each stage, plus the rt of the EX instruction.
  int         ex_k = K_NOP, mem_k = K_NOP, wb_k = K_NOP;
  logic [4:0] ex_rt_m = '0;
  bit         ill_m = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [5:0] op, input bit v);
    if (!v) return K_NOP;
    if (op == C_R) return K_R;
    if (op == C_LW) return K_LW;
    if (op == C_SW) return K_SW;
    if (op == C_BEQ) return K_BEQ;
    if (op == C_ADDI) return K_ADDI;
    return K_NOP;
  endfunction

  task automatic check_outputs(input bit e_pc, input bit e_ifid, input bit chk_ifid,
                               input bit e_flush);
    logic [2:0] e_alu;
    e_alu = (ex_k == K_R) ? 3'd2 : (ex_k == K_BEQ) ? 3'd1 : (ex_k == K_ADDI) ? 3'd3 : 3'd0;
    check_eq("exRegDst", exRegDst, ex_k == K_R);
    check_eq("exAluSrc", exAluSrc, ex_k == K_LW || ex_k == K_SW || ex_k == K_ADDI);
    check_eq("exAluOp", exAluOp, e_alu);
    check_eq("exBranch", exBranch, ex_k == K_BEQ);
    check_eq("memMemRead", memMemRead, mem_k == K_LW);
    check_eq("memMemWrite", memMemWrite, mem_k == K_SW);
    check_eq("wbMemToReg", wbMemToReg, wb_k == K_LW);
    check_eq("wbRegWrite", wbRegWrite, wb_k == K_R || wb_k == K_LW || wb_k == K_ADDI);
    check_eq("pcWrite", pcWrite, e_pc);
    if (chk_ifid) check_eq("ifIdWrite", ifIdWrite, e_ifid);
    check_eq("ifIdFlush", ifIdFlush, e_flush);
`ifdef CTRL_ILLEGAL_TRAP_EN
    check_eq("illegalOp", illegalOp, ill_m);
`endif
  endtask

  // One cycle: drive at negedge, check the pre-edge view, then advance the model.
  task automatic step(input logic [5:0] op, input bit v, input logic [4:0] rs,
                      input logic [4:0] rt, input bit busy, input bit br);
    int  k;
    bit  haz;
    @(negedge clk);
    opCode = op; idValid = v; idRs = rs; idRt = rt;
    exRt = ex_rt_m; memBusy = busy; branchTaken = br;
    #1;
    k   = kind_of(op, v);
    haz = (ex_k == K_LW) && (ex_rt_m != 0) && v &&
          ((ex_rt_m == rs) || ((ex_rt_m == rt) && (k == K_R || k == K_BEQ || k == K_SW)));
    if (busy) begin
      check_outputs(1'b0, 1'b0, 1'b1, 1'b0);
    end else if (br) begin
      check_outputs(1'b1, 1'b0, 1'b0, 1'b1);
      wb_k = mem_k; mem_k = ex_k; ex_k = K_NOP; ex_rt_m = '0;
    end else if (haz) begin
      check_outputs(1'b0, 1'b0, 1'b1, 1'b0);
      wb_k = mem_k; mem_k = ex_k; ex_k = K_NOP; ex_rt_m = '0;
    end else begin
      check_outputs(1'b1, 1'b1, 1'b1, 1'b0);
      wb_k = mem_k; mem_k = ex_k; ex_k = k; ex_rt_m = rt;
    end
    if (v && op != C_R && op != C_LW && op != C_SW && op != C_BEQ && op != C_ADDI &&
        !busy && !br) ill_m = 1'b1;
  endtask

  // Asynchronous reset mid-cycle; leaves memBusy high so nothing moves until the next step.
  task automatic do_reset();
    @(negedge clk);
    #2;
    resetN = 1'b0;
    memBusy = 1'b1;
    branchTaken = ($urandom_range(0, 1) == 1);
    #1;
    ex_k = K_NOP; mem_k = K_NOP; wb_k = K_NOP; ex_rt_m = '0; ill_m = 1'b0;
    check_outputs(1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs(1'b1, 1'b1, 1'b1, 1'b0);
    resetN = 1'b1;
    branchTaken = 1'b0;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 7))
      0, 1: return C_R;
      2:    return C_LW;
      3:    return C_SW;
      4:    return C_BEQ;
      5:    return C_ADDI;
      6:    return C_BAD;
      default: return 6'($urandom_range(0, 63));
    endcase
  endfunction

  initial begin
    bit prev_busy;
    prev_busy = 1'b0;
    #1;
    check_outputs(1'b1, 1'b1, 1'b1, 1'b0);
    do_reset();

    // lw then independent R-type through all stages
    step(C_LW, 1, 5'd1, 5'd2, 0, 0);
    step(C_R,  1, 5'd3, 5'd4, 0, 0);
    repeat (3) step(C_R, 0, 5'd0, 5'd0, 0, 0);
    // load-use stall then R-type advances
    step(C_LW, 1, 5'd0, 5'd5, 0, 0);
    step(C_R,  1, 5'd5, 5'd6, 0, 0);
    step(C_R,  1, 5'd5, 5'd6, 0, 0);
    // rt=0 never stalls
    step(C_LW, 1, 5'd0, 5'd0, 0, 0);
    step(C_R,  1, 5'd0, 5'd0, 0, 0);
    // sw frozen for three cycles
    step(C_SW, 1, 5'd1, 5'd2, 0, 0);
    step(C_R,  0, 5'd0, 5'd0, 0, 0);
    repeat (3) step(C_R, 0, 5'd0, 5'd0, 1, 0);
    repeat (3) step(C_R, 0, 5'd0, 5'd0, 0, 0);
    // taken branch flushes addi in ID, older R-type completes
    step(C_R,    1, 5'd1, 5'd2, 0, 0);
    step(C_ADDI, 1, 5'd3, 5'd4, 0, 1);
    repeat (3) step(C_R, 0, 5'd0, 5'd0, 0, 0);
    // branch + load-use: flush wins; adding memBusy: freeze wins
    step(C_LW, 1, 5'd0, 5'd7, 0, 0);
    step(C_R,  1, 5'd7, 5'd0, 0, 1);
    step(C_LW, 1, 5'd0, 5'd7, 0, 0);
    step(C_R,  1, 5'd7, 5'd0, 1, 1);
    step(C_R,  1, 5'd7, 5'd0, 0, 1);
    // illegal opcode decodes as NOP; sticky flag until reset
    step(C_BAD, 1, 5'd0, 5'd0, 0, 0);
    repeat (3) step(C_R, 1, 5'd1, 5'd1, 0, 0);
    do_reset();
    step(C_R, 0, 5'd0, 5'd0, 0, 0);

    for (int i = 0; i < 800; i++) begin
      bit busy;
      if (prev_busy && $urandom_range(0, 30) == 0) begin
        do_reset();
        prev_busy = 1'b0;
      end
      busy = ($urandom_range(0, 4) == 0);
      step(rand_op(), $urandom_range(0, 9) != 0, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), busy, $urandom_range(0, 9) == 0);
      prev_busy = busy;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Sequential successor to the combinational `ControlUnit`. It decodes the ID-stage opcode into a control bundle and carries that bundle through the ID/EX, EX/MEM and MEM/WB registers. It also detects load-use hazards and applies three controls:

- stall, for load-use hazards;
- freeze, when the data cache reports busy;
- flush, for a taken branch.

It sits between the IF/ID register and the datapath stage registers. It owns every control bit the datapath consumes.

## Interface
- `OPCODE_WIDTH`, 6: opcode field width.
- `ALUOP_WIDTH`, 3: ALU operation code width.
- `REG_ADDR_WIDTH`, 5: register specifier width.
- `clk`  in  1  rising-edge clock.
- `resetN`  in  1  asynchronous, active-low reset.
- `opCode`  in  `OPCODE_WIDTH`  ID-stage opcode.
- `idValid`  in  1  ID stage holds a real instruction.
- `idRs`, `idRt`  in  `REG_ADDR_WIDTH`  ID-stage source registers.
- `exRt`  in  `REG_ADDR_WIDTH`  rt of the instruction currently in EX.
- `memBusy`  in  1  data cache miss in progress; freezes the pipe.
- `branchTaken`  in  1  taken branch resolved in EX (registered by datapath).
- `pcWrite`, `ifIdWrite`  out  1  PC / IF/ID enable.
- `ifIdFlush`  out  1  clear IF/ID next edge.
- `exRegDst`, `exAluSrc`  out  1  EX-stage controls.
- `exAluOp`  out  `ALUOP_WIDTH`  EX-stage ALU operation.
- `exBranch`  out  1  EX-stage branch control.
- `memMemRead`, `memMemWrite`  out  1  MEM-stage controls.
- `wbMemToReg`, `wbRegWrite`  out  1  WB-stage controls.
- `illegalOp`  out  1  sticky illegal-opcode flag (`CTRL_ILLEGAL_TRAP_EN` only).

## Operation
- Decode (combinational, ID). All other control bits are 0 unless listed.
  - `000000` R-type: regDst=1, regWrite=1, aluOp=`010`.
  - `100011` lw: aluSrc=1, memToReg=1, regWrite=1, memRead=1, aluOp=`000`.
  - `101011` sw: aluSrc=1, memWrite=1, aluOp=`000`.
  - `000100` beq: branch=1, aluOp=`001`.
  - `001000` addi: aluSrc=1, regWrite=1, aluOp=`011`.
  - Any other opcode, or `idValid`=0: all-zero bundle (NOP).
- Bundle layout: 10 bits, `{regDst, aluSrc, aluOp, branch, memRead, memWrite, memToReg, regWrite}`.
- Pipeline registers:
  - ID/EX holds the full bundle.
  - EX/MEM drops regDst, aluSrc, aluOp and branch.
  - MEM/WB keeps memToReg and regWrite.
- Load-use hazard = ID/EX.memRead && exRt≠0 && (exRt==idRs || (exRt==idRt && op∈{R-type, beq, sw})) && idValid.
- Event priority, highest first; the first matching event decides the cycle:
  - `memBusy`: every register holds its value; pcWrite=0, ifIdWrite=0, ifIdFlush=0.
  - `branchTaken`: ID/EX←bubble; EX/MEM advances normally; ifIdFlush=1; pcWrite=1.
  - Load-use hazard: ID/EX←bubble; pcWrite=0, ifIdWrite=0.
  - Otherwise: all registers advance; pcWrite=1, ifIdWrite=1.
- Bubble = all-zero bundle.

## Timing
- Async reset clears all stage registers to zero, so every stage output is 0 during reset.
- pcWrite and ifIdWrite are 1 during reset; ifIdFlush and illegalOp are 0.
- Decode → EX outputs: 1 cycle. → MEM outputs: 2 cycles. → WB outputs: 3 cycles.
- pcWrite, ifIdWrite and ifIdFlush are combinational from the current inputs and register state.
- A load-use stall lasts exactly 1 cycle. After it, ID/EX holds a bubble, so the hazard clears.
- `memBusy` held for N cycles freezes the pipe for N cycles; resume is seamless, with no lost or duplicated bundle.
- `memBusy` and `branchTaken` together: freeze wins. The datapath holds `branchTaken`, and the flush applies on the first non-busy cycle.
- Reset asserted mid-stall or mid-freeze: all registers clear immediately. No state survives.

## Configuration
- `CTRL_ILLEGAL_TRAP_EN` defined:
  - An illegal opcode with idValid=1 sets `illegalOp` on the next edge, unless that cycle is frozen or flushed.
  - `illegalOp` is sticky until reset.
  - The instruction still decodes as a NOP.
- Not defined: the `illegalOp` port is absent, and illegal opcodes are silent NOPs.

## Structure
- Shared package `ctrl_pkg` holds:
  - opcode constants (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_ADDI`);
  - aluOp constants;
  - the control bundle struct/width and the bubble constant.
- One sub-module, `control_decoder`: the combinational opcode→bundle table, reused from the single-cycle flow.

## Test plan
- Reset, then lw (`100011`) then R-type: exAluSrc=1 at cycle 1; memMemRead=1 at cycle 2; wbMemToReg=1 at cycle 3; R-type exRegDst=1 one cycle behind each.
- lw to rt=5 followed by R-type with rs=5: one cycle with pcWrite=0 and ifIdWrite=0, ID/EX bubble; the R-type appears in EX one cycle later. With rs=0 and rt=0 there is no stall.
- `memBusy` high 3 cycles during a sw: all outputs constant for those 3 cycles; memMemWrite=1 remains until release, then advances.
- `branchTaken`=1 with addi in ID: ifIdFlush=1, the addi never produces wbRegWrite=1, and the in-flight older instruction still completes.
- `branchTaken` and load-use hazard in the same cycle: flush behaviour, pcWrite=1; `memBusy` added to the same cycle: full freeze.
- Opcode `111111` with idValid=1: NOP bundle. With the macro, illegalOp=1 next cycle and it stays set until resetN=0.
